light_ctrl_multi: RTL and testbench

Parametrised successor to the single-channel lamp controller: drives N_CH independent lamp channels, each with an on/off/timed mode FSM, a stepped brightness level rendered as PWM, and an auto-off countdown. It sits between the debounced button/pulse layer and the board lamp pins, and is gated by the global power_on. One shared prescaler and PWM counter serve all channels.

---
 rtl/light_pkg.sv | 26 ++
 rtl/light_channel.sv | 93 +++++++++
 rtl/light_ctrl_multi.sv | 70 +++++++
 tb/tb_light_ctrl_multi.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared definitions for the multi-channel lamp controller.
//   light_state_e : per-channel mode (off, steadily on, timed auto-off)
//   cnt_width     : countdown width able to hold 0..auto_off_ticks
//   presc_width   : prescaler width able to hold 0..tick_div-1
//   level_max     : brightest level for a given PWM resolution
package light_pkg;

  typedef enum logic [1:0] {
    LIGHT_OFF   = 2'd0,
    LIGHT_ON    = 2'd1,
    LIGHT_TIMED = 2'd2
  } light_state_e;

  function automatic int cnt_width(input int auto_off_ticks);
    return $clog2(auto_off_ticks + 1);
  endfunction

  function automatic int presc_width(input int tick_div);
    return $clog2(tick_div);
  endfunction

  function automatic int level_max(input int pwm_bits);
    return (1 << pwm_bits) - 1;
  endfunction

endpackage

// File: rtl/light_channel.sv
// One lamp channel: mode FSM, brightness level, auto-off countdown and the
// registered PWM drive for its pin.
//   clk, reset     : system clock, asynchronous active-low reset
//   power_on       : global enable; low forces the channel OFF
//   tick           : one-cycle timer tick shared by all channels
//   pwm_cnt        : shared free-running PWM counter
//   btn_toggle     : pulse, toggle on/off
//   btn_timed      : pulse, enter/restart timed mode
//   btn_dim        : pulse, step brightness down (1 wraps to max)
//   light_on       : registered lamp drive
//   level          : current brightness, never 0
//   timed_active   : high while in timed mode
module light_channel
  import light_pkg::*;
#(
  parameter int PWM_BITS       = 4,
  parameter int AUTO_OFF_TICKS = 60
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                power_on,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                btn_toggle,
  input  logic                btn_timed,
  input  logic                btn_dim,
  output logic                light_on,
  output logic [PWM_BITS-1:0] level,
  output logic                timed_active
);

  localparam int                  CNT_W    = cnt_width(AUTO_OFF_TICKS);
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(AUTO_OFF_TICKS);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = PWM_BITS'(level_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);

  light_state_e        state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [PWM_BITS-1:0] level_nxt;
  logic                light_nxt;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the
    // block leaves it unassigned, which would infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;

    // Mode changes in priority order: power, toggle, timed, countdown.
    if (!power_on) begin
      state_nxt = LIGHT_OFF;
      cnt_nxt   = '0;
    end else if (btn_toggle) begin
      state_nxt = (state == LIGHT_OFF) ? LIGHT_ON : LIGHT_OFF;
      cnt_nxt   = '0;
    end else if (btn_timed) begin
      state_nxt = LIGHT_TIMED;
      cnt_nxt   = CNT_LOAD;
    end else if (state == LIGHT_TIMED && tick) begin
      cnt_nxt = cnt - CNT_ONE;
      // The tick that empties the countdown also turns the lamp off.
      if (cnt == CNT_ONE) state_nxt = LIGHT_OFF;
    end

    // Dimming works in any mode but not while the board is powered down.
    if (power_on && btn_dim) begin
      level_nxt = (level == LVL_ONE) ? LVL_MAX : level - LVL_ONE;
    end

    // Max level bypasses the compare so the lamp is steady with no PWM gap.
    light_nxt = (state != LIGHT_OFF) && ((level == LVL_MAX) || (pwm_cnt < level));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LIGHT_OFF;
      cnt      <= '0;
      level    <= LVL_MAX;
      light_on <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      level    <= level_nxt;
      light_on <= light_nxt;
    end
  end

  assign timed_active = (state == LIGHT_TIMED);

endmodule

// File: rtl/light_ctrl_multi.sv
// N_CH-channel lamp controller. Holds the shared timer prescaler and PWM
// counter and instantiates one light_channel per lamp.
//   clk, reset   : system clock, asynchronous active-low reset
//   power_on     : global enable; low forces every channel OFF
//   btn_toggle   : per-channel pulse, toggle on/off
//   btn_timed    : per-channel pulse, start/restart timed mode
//   btn_dim      : per-channel pulse, step brightness down with wrap
//   light_on     : per-channel registered PWM lamp drive
//   level        : per-channel brightness, channel i at [i*PWM_BITS +: PWM_BITS]
//   timed_active : per-channel, high while in timed mode
module light_ctrl_multi
  import light_pkg::*;
#(
  parameter int N_CH           = 2,
  parameter int PWM_BITS       = 4,
  parameter int TICK_DIV       = 100_000_000,
  parameter int AUTO_OFF_TICKS = 60
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     power_on,
  input  logic [N_CH-1:0]          btn_toggle,
  input  logic [N_CH-1:0]          btn_timed,
  input  logic [N_CH-1:0]          btn_dim,
  output logic [N_CH-1:0]          light_on,
  output logic [N_CH*PWM_BITS-1:0] level,
  output logic [N_CH-1:0]          timed_active
);

  localparam int                 PRESC_W   = presc_width(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0]  presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;

  // Tick is high during the last prescaler count, so it is consumed on the
  // same edge that wraps the prescaler back to 0.
  assign tick = (presc == PRESC_TOP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc   <= tick ? '0 : presc + PRESC_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    light_channel #(
      .PWM_BITS       (PWM_BITS),
      .AUTO_OFF_TICKS (AUTO_OFF_TICKS)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .power_on     (power_on),
      .tick         (tick),
      .pwm_cnt      (pwm_cnt),
      .btn_toggle   (btn_toggle[i]),
      .btn_timed    (btn_timed[i]),
      .btn_dim      (btn_dim[i]),
      .light_on     (light_on[i]),
      .level        (level[i*PWM_BITS +: PWM_BITS]),
      .timed_active (timed_active[i])
    );
  end

endmodule

// File: tb/tb_light_ctrl_multi.sv
// Directed bench for light_ctrl_multi with N_CH=2, PWM_BITS=4, TICK_DIV=10,
// AUTO_OFF_TICKS=3. Inputs change and outputs are sampled on the falling edge.
// A bench-side edge counter, cleared by reset, locates timer ticks: the
// prescaler wraps (and a tick takes effect) on every edge whose count since
// reset release is a multiple of 10.
module tb_light_ctrl_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       power_on;
  logic [1:0] btn_toggle, btn_timed, btn_dim;
  logic [1:0] light_on;
  logic [7:0] level;
  logic [1:0] timed_active;

  int checks   = 0;
  int failures = 0;
  int e_cnt;

  light_ctrl_multi #(
    .N_CH           (2),
    .PWM_BITS       (4),
    .TICK_DIV       (10),
    .AUTO_OFF_TICKS (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .power_on     (power_on),
    .btn_toggle   (btn_toggle),
    .btn_timed    (btn_timed),
    .btn_dim      (btn_dim),
    .light_on     (light_on),
    .level        (level),
    .timed_active (timed_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) e_cnt <= 0;
    else        e_cnt <= e_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, e_cnt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(input logic [1:0] tog, input logic [1:0] tim, input logic [1:0] dim);
    btn_toggle = tog;
    btn_timed  = tim;
    btn_dim    = dim;
    step();
    btn_toggle = 2'b00;
    btn_timed  = 2'b00;
    btn_dim    = 2'b00;
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (e_cnt < target && guard < 1000) begin
      step();
      guard++;
    end
    check("run_to", e_cnt, target);
  endtask

  task automatic count_high(input int ch, output int n);
    n = 0;
    for (int k = 0; k < 16; k++) begin
      n += int'(light_on[ch]);
      step();
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ld;
    int exp_off;
    int t2;

    reset      = 1'b1;
    power_on   = 1'b0;
    btn_toggle = 2'b00;
    btn_timed  = 2'b00;
    btn_dim    = 2'b00;

    // Power-up reset
    #2 reset = 1'b0;
    #1;
    check("rst_light_on", light_on, 2'b00);
    check("rst_timed",    timed_active, 2'b00);
    check("rst_level",    level, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b1;
    power_on = 1'b1;

    // ch0 on at max level: steady high
    pulse(2'b01, 2'b00, 2'b00);
    step();
    check("on_light", light_on, 2'b01);
    count_high(0, n);
    check("max_steady", n, 16);
    check("on_level", level, 8'hFF);

    // Asynchronous reset mid-run, between clock edges
    #2 reset = 1'b0;
    #1;
    check("async_light_on", light_on, 2'b00);
    check("async_timed",    timed_active, 2'b00);
    check("async_level",    level, 8'hFF);
    @(negedge clk);
    reset = 1'b1;

    // ch0 on, dim twice -> 13, 13 of 16 cycles high
    pulse(2'b01, 2'b00, 2'b00);
    pulse(2'b00, 2'b00, 2'b01);
    pulse(2'b00, 2'b00, 2'b01);
    check("dim_level13", level, 8'hFD);
    step();
    count_high(0, n);
    check("pwm_13_of_16", n, 13);

    // ch1 dimmed down to 1, then wrap to 15
    for (int k = 0; k < 14; k++) pulse(2'b00, 2'b00, 2'b10);
    check("ch1_level1", level[7:4], 4'd1);
    pulse(2'b00, 2'b00, 2'b10);
    check("ch1_wrap", level[7:4], 4'd15);
    check("ch0_untouched", level[3:0], 4'd13);

    // ch1 timed: off on the third tick after load
    pulse(2'b00, 2'b10, 2'b00);
    ld      = e_cnt;
    exp_off = (ld / 10 + 3) * 10;
    check("timed_enter", timed_active, 2'b10);
    run_to(exp_off - 1);
    check("timed_before_exp", timed_active[1], 1'b1);
    step();
    check("timed_expired", timed_active[1], 1'b0);
    step();
    check("timed_light_off", light_on[1], 1'b0);

    // ch1 timed, re-press after two ticks -> three more ticks
    pulse(2'b00, 2'b10, 2'b00);
    ld = e_cnt;
    t2 = (ld / 10 + 2) * 10;
    run_to(t2);
    check("repress_still_timed", timed_active[1], 1'b1);
    pulse(2'b00, 2'b10, 2'b00);
    exp_off = t2 + 30;
    run_to(exp_off - 1);
    check("repress_before_exp", timed_active[1], 1'b1);
    step();
    check("repress_expired", timed_active[1], 1'b0);

    // ch0: off, then toggle+timed together from OFF -> ON (toggle wins)
    pulse(2'b01, 2'b00, 2'b00);
    step();
    check("ch0_off", light_on[0], 1'b0);
    pulse(2'b01, 2'b01, 2'b00);
    check("tog_tim_not_timed", timed_active[0], 1'b0);
    step();
    count_high(0, n);
    check("tog_tim_is_on", n, 13);

    // ch0 timed, toggle on the expiry tick -> OFF
    pulse(2'b00, 2'b01, 2'b00);
    ld      = e_cnt;
    exp_off = (ld / 10 + 3) * 10;
    run_to(exp_off - 1);
    check("ch0_timed_pre", timed_active[0], 1'b1);
    pulse(2'b01, 2'b00, 2'b00);
    check("tog_on_expiry", timed_active[0], 1'b0);
    step();
    check("tog_on_expiry_light", light_on[0], 1'b0);

    // ch1 timed, timed re-press on the expiry tick -> reload
    pulse(2'b00, 2'b10, 2'b00);
    ld      = e_cnt;
    exp_off = (ld / 10 + 3) * 10;
    run_to(exp_off - 1);
    pulse(2'b00, 2'b10, 2'b00);
    check("tim_on_expiry_reload", timed_active[1], 1'b1);
    run_to(exp_off + 29);
    check("reload_before_exp", timed_active[1], 1'b1);
    step();
    check("reload_expired", timed_active[1], 1'b0);

    // Power drop with both channels lit; dims ignored while off
    pulse(2'b00, 2'b11, 2'b00);
    check("both_timed", timed_active, 2'b11);
    step();
    check("ch1_lit", light_on[1], 1'b1);
    power_on = 1'b0;
    pulse(2'b00, 2'b00, 2'b11);
    check("pwr_off_state", timed_active, 2'b00);
    step();
    check("pwr_off_light", light_on, 2'b00);
    check("pwr_off_level", level, 8'hFD);
    for (int k = 0; k < 3; k++) pulse(2'b00, 2'b00, 2'b11);
    check("pwr_off_dim_ignored", level, 8'hFD);
    power_on = 1'b1;
    step();
    step();
    step();
    check("pwr_back_state", timed_active, 2'b00);
    check("pwr_back_light", light_on, 2'b00);
    check("pwr_back_level", level, 8'hFD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
